// File: rtl/rv32i_instr_encoder.sv
// Purpose: packs decoded RV32I fields into 32-bit words and queues them for the imem write port.
// Latency: 1 cycle from accept to out_valid when the queue is empty; no same-cycle bypass.
// Backpressure: in_ready drops while the queue is full and depends only on registered occupancy.

// Generic circular-buffer FIFO with occupancy count; head data reads as zero when empty.
// Latency: a push is visible at the head one cycle later; no write-to-read bypass.
// Backpressure: push_rdy is a function of the registered count only, never of pop_rdy.
module sync_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_vld,
  output logic             push_rdy,
  input  logic [WIDTH-1:0] push_dat,
  output logic             pop_vld,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat
);

  // A one-entry FIFO still needs a 1-bit pointer to index the storage.
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [CW-1:0]    count;
  logic             push;
  logic             pop;

  assign push_rdy = (count < CW'(DEPTH));
  assign pop_vld  = (count != '0);
  assign push     = push_vld && push_rdy;
  assign pop      = pop_vld && pop_rdy;

  // Empty queue presents zeros so the consumer never sees stale words.
  assign pop_dat  = pop_vld ? mem[rd_ptr] : '0;

  // Storage holds data only; validity lives in count, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; pointers wrap at DEPTH-1 so any depth works.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// Encoder top: combinational field packing and immediate range check, then the output FIFO.
// Latency: request accepted at edge N is at the FIFO head after edge N.
// Backpressure: in_ready = FIFO not full; head outputs hold while out_valid && !out_ready.
module rv32i_instr_encoder #(
  parameter int DEPTH = 2,
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_fmt,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_fn3,
  input  logic [6:0]       in_fn7,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [31:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [2:0]  FMT_R = 3'd0;
  localparam logic [2:0]  FMT_I = 3'd1;
  localparam logic [2:0]  FMT_S = 3'd2;
  localparam logic [2:0]  FMT_B = 3'd3;
  localparam logic [2:0]  FMT_U = 3'd4;
  localparam logic [2:0]  FMT_J = 3'd5;

  localparam logic [6:0]  OP_IMM = 7'b0010011;
  // addi x0, x0, 0: a harmless word stored in place of anything unencodable.
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef struct packed {
    logic        err;
    logic [31:0] instr;
  } enc_entry_t;

  logic        accept;
  logic        is_shift;
  logic        imm12_ok;
  logic        shamt_ok;
  logic        b_imm_ok;
  logic        u_imm_ok;
  logic        j_imm_ok;
  logic        imm_ok;
  logic        fmt_ok;
  logic        req_err;
  logic [31:0] enc_instr;
  enc_entry_t  enc_entry;
  enc_entry_t  head_entry;

  assign accept = in_valid && in_ready;

  // Shifts reuse the I layout but carry fn7 in the top bits and a 5-bit shamt.
  assign is_shift = (in_fmt == FMT_I) && (in_opcode == OP_IMM) &&
                    ((in_fn3 == 3'b001) || (in_fn3 == 3'b101));

  // Range checks: the dropped upper bits must be a pure sign extension of the kept field.
  assign imm12_ok = (&in_imm[31:11]) | ~(|in_imm[31:11]);
  assign shamt_ok = ~(|in_imm[31:5]);
  assign b_imm_ok = ((&in_imm[31:12]) | ~(|in_imm[31:12])) & ~in_imm[0];
  assign u_imm_ok = ~(|in_imm[11:0]);
  assign j_imm_ok = ((&in_imm[31:20]) | ~(|in_imm[31:20])) & ~in_imm[0];

  // Field packing per format; exactly the inverse of the decoder's extraction.
  always_comb begin
    enc_instr      = '0;
    imm_ok         = 1'b1;
    fmt_ok         = 1'b1;
    enc_instr[6:0] = in_opcode;
    case (in_fmt)
      FMT_R: begin
        enc_instr[11:7]  = in_rd;
        enc_instr[14:12] = in_fn3;
        enc_instr[19:15] = in_rs1;
        enc_instr[24:20] = in_rs2;
        enc_instr[31:25] = in_fn7;
      end
      FMT_I: begin
        enc_instr[11:7]  = in_rd;
        enc_instr[14:12] = in_fn3;
        enc_instr[19:15] = in_rs1;
        if (is_shift) begin
          enc_instr[24:20] = in_imm[4:0];
          enc_instr[31:25] = in_fn7;
          imm_ok           = shamt_ok;
        end else begin
          enc_instr[31:20] = in_imm[11:0];
          imm_ok           = imm12_ok;
        end
      end
      FMT_S: begin
        enc_instr[11:7]  = in_imm[4:0];
        enc_instr[14:12] = in_fn3;
        enc_instr[19:15] = in_rs1;
        enc_instr[24:20] = in_rs2;
        enc_instr[31:25] = in_imm[11:5];
        imm_ok           = imm12_ok;
      end
      FMT_B: begin
        enc_instr[7]     = in_imm[11];
        enc_instr[11:8]  = in_imm[4:1];
        enc_instr[14:12] = in_fn3;
        enc_instr[19:15] = in_rs1;
        enc_instr[24:20] = in_rs2;
        enc_instr[30:25] = in_imm[10:5];
        enc_instr[31]    = in_imm[12];
        imm_ok           = b_imm_ok;
      end
      FMT_U: begin
        enc_instr[11:7]  = in_rd;
        enc_instr[31:12] = in_imm[31:12];
        imm_ok           = u_imm_ok;
      end
      FMT_J: begin
        enc_instr[11:7]  = in_rd;
        enc_instr[19:12] = in_imm[19:12];
        enc_instr[20]    = in_imm[11];
        enc_instr[30:21] = in_imm[10:1];
        enc_instr[31]    = in_imm[20];
        imm_ok           = j_imm_ok;
      end
      default: begin
        fmt_ok = 1'b0;
      end
    endcase
  end

  assign req_err         = !(imm_ok && fmt_ok);
  assign enc_entry.err   = req_err;
  assign enc_entry.instr = req_err ? NOP_WORD : enc_instr;

  sync_fifo #(
    .WIDTH ($bits(enc_entry_t)),
    .DEPTH (DEPTH)
  ) u_out_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push_vld (in_valid),
    .push_rdy (in_ready),
    .push_dat (enc_entry),
    .pop_vld  (out_valid),
    .pop_rdy  (out_ready),
    .pop_dat  (head_entry)
  );

  assign out_instr = head_entry.instr;
  assign out_err   = head_entry.err;

  // Count accepted bad requests, sticking at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count <= '0;
    end else if (accept && req_err && (err_count != {ERR_W{1'b1}})) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

endmodule
